// File: rtl/pipelined_adder_pkg.sv
// Shared constants for the pipelined adder: default geometry and flag bit positions.
// Optional flags output is enabled by defining PIPELINED_ADDER_FLAGS_EN.
package pipelined_adder_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Assemble the {N,Z,C,V} nibble from its individual bits using the index constants.
  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// The flags signal exists only when PIPELINED_ADDER_FLAGS_EN is defined.
interface pipelined_adder_if
  import pipelined_adder_pkg::*;
  #(parameter int WIDTH = DEF_WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef PIPELINED_ADDER_FLAGS_EN
  logic [3:0]       flags;

  modport master (output in_valid, a, b, cin, sub, out_ready,
                  input  in_ready, out_valid, sum, cout, flags);
  modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                  output in_ready, out_valid, sum, cout, flags);
`else
  modport master (output in_valid, a, b, cin, sub, out_ready,
                  input  in_ready, out_valid, sum, cout);
  modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                  output in_ready, out_valid, sum, cout);
`endif

endinterface

// File: rtl/pipelined_adder_chunk.sv
// One CW-bit slice of the pipelined adder: combinational add with carry in and out.
module adder_chunk #(
  parameter int CW = 8
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] s,
  output logic          cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};

endmodule

// File: rtl/pipelined_adder.sv
// Carry-pipelined adder/subtractor: one CW-bit chunk per stage, valid/ready flow control.
// Define PIPELINED_ADDER_FLAGS_EN to add the registered {N,Z,C,V} flags output.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input logic               clk,
  input logic               rst_n,
  pipelined_adder_if.slave  bus
);

  localparam int CW = WIDTH / STAGES;

  logic             adv_s;
  logic [WIDTH-1:0] b_eff_s;

  assign b_eff_s = bus.sub ? ~bus.b : bus.b;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // RW: operand bits still to be added on entry; DW: sum bits finished on exit.
    localparam int RW = WIDTH - k * CW;
    localparam int DW = (k + 1) * CW;

    logic [RW-1:0] pa_s;
    logic [RW-1:0] pb_s;
    logic          pc_s;
    logic          pv_s;
    logic [CW-1:0] chunk_s;
    logic          co_s;
    logic [DW-1:0] ns_s;
    logic [DW-1:0] s_r;
    logic          c_r;
    logic          v_r;

    if (k == 0) begin : g_src
      assign pa_s = bus.a;
      assign pb_s = b_eff_s;
      assign pc_s = bus.cin;
      assign pv_s = bus.in_valid;
      assign ns_s = chunk_s;
    end else begin : g_src
      assign pa_s = g_stage[k-1].g_fwd.a_r;
      assign pb_s = g_stage[k-1].g_fwd.b_r;
      assign pc_s = g_stage[k-1].c_r;
      assign pv_s = g_stage[k-1].v_r;
      assign ns_s = {chunk_s, g_stage[k-1].s_r};
    end

    adder_chunk #(.CW(CW)) u_chunk (
      .a    (pa_s[CW-1:0]),
      .b    (pb_s[CW-1:0]),
      .cin  (pc_s),
      .s    (chunk_s),
      .cout (co_s)
    );

    // Stage valid, finished sum bits and chunk carry; frozen while the output is stalled.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_r <= 1'b0;
        c_r <= 1'b0;
        s_r <= '0;
      end else if (adv_s) begin
        v_r <= pv_s;
        c_r <= co_s;
        s_r <= ns_s;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [RW-CW-1:0] a_r;
      logic [RW-CW-1:0] b_r;

      // Unprocessed upper operand chunks ride along to the next stage.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_r <= '0;
          b_r <= '0;
        end else if (adv_s) begin
          a_r <= pa_s[RW-1:CW];
          b_r <= pb_s[RW-1:CW];
        end
      end
    end

`ifdef PIPELINED_ADDER_FLAGS_EN
    if (k == STAGES - 1) begin : g_flags
      logic [3:0] flags_r;

      // Flags are formed from the completed sum and registered alongside it.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          flags_r <= 4'b0000;
        end else if (adv_s) begin
          flags_r <= pack_flags(ns_s[DW-1],
                                (ns_s == {DW{1'b0}}),
                                co_s,
                                (pa_s[CW-1] == pb_s[CW-1]) && (ns_s[DW-1] != pa_s[CW-1]));
        end
      end
    end
`endif
  end

  assign adv_s         = !g_stage[STAGES-1].v_r || bus.out_ready;
  assign bus.in_ready  = adv_s || !rst_n;
  assign bus.out_valid = g_stage[STAGES-1].v_r;
  assign bus.sum       = g_stage[STAGES-1].s_r;
  assign bus.cout      = g_stage[STAGES-1].c_r;
`ifdef PIPELINED_ADDER_FLAGS_EN
  assign bus.flags     = g_stage[STAGES-1].g_flags.flags_r;
`endif

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and sum width in bits.
REQ-002 SHALL have parameter STAGES, default 4: pipeline depth; WIDTH SHALL be divisible by STAGES, chunk width CW = WIDTH/STAGES.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operands present.
REQ-006 SHALL have port in_ready  output  1  operands accepted when in_valid && in_ready.
REQ-007 SHALL have ports a, b  input  WIDTH  operands.
REQ-008 SHALL have port cin  input  1  carry in.
REQ-009 SHALL have port sub  input  1  1: b is bitwise inverted before addition.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  result consumed when out_valid && out_ready.
REQ-012 SHALL have port sum  output  WIDTH  result.
REQ-013 SHALL have port cout  output  1  carry out of bit WIDTH-1.
REQ-014 SHALL have port flags  output  4  {N,Z,C,V}, present only under PIPELINED_ADDER_FLAGS_EN.

Function
REQ-015 Result SHALL equal {cout,sum} = a + (sub ? ~b : b) + cin, modulo 2^(WIDTH+1); SUB uses sub=1,cin=1; SBC passes carry as cin.
REQ-016 Stage k (0..STAGES-1) SHALL add chunk k of the operands plus the carry registered by stage k-1 (stage 0 uses cin); unprocessed upper chunks and finished lower sum chunks SHALL be carried along in stage registers.
REQ-017 Latency SHALL be exactly STAGES cycles from accept to out_valid with out_ready held high.
REQ-018 Throughput SHALL be one transaction per cycle when out_ready is high.
REQ-019 Pipeline SHALL advance when adv = !out_valid || out_ready; all stages advance together; in_ready = adv.
REQ-020 When adv is low, every stage register, including sum/cout/flags, SHALL hold its value.
REQ-021 Empty slots (bubbles) SHALL propagate with valid=0; out_valid SHALL be the last stage's valid bit.
REQ-022 Results SHALL emerge in acceptance order; none dropped or duplicated.
REQ-023 sum/cout/flags SHALL be stable while out_valid && !out_ready.
REQ-024 in_valid low with adv high SHALL insert a bubble.
REQ-025 STAGES=1 SHALL yield a single registered full-width adder with latency 1.

Reset
REQ-026 With rst_n low at a clock edge, all stage valid bits, out_valid, sum, cout and flags SHALL become 0 on that edge; in-flight transactions discarded.
REQ-027 in_ready SHALL be 1 during and after reset (pipeline empty).
REQ-028 First accept SHALL be possible on the first edge with rst_n high.

Configuration
REQ-029 Macro PIPELINED_ADDER_FLAGS_EN defined: flags port and final-stage flag logic SHALL exist: N=sum[WIDTH-1], Z=(sum==0), C=cout, V=(a[MSB]==b_eff[MSB]) && (sum[MSB]!=a[MSB]), b_eff = sub ? ~b : b; flags registered with sum, same latency.
REQ-030 Macro undefined: flags port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-031 Package pipelined_adder_pkg SHALL hold flag bit-index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0) and default WIDTH/STAGES constants.
REQ-032 Sub-module adder_chunk SHALL implement one CW-bit add with carry in/out, instantiated STAGES times by generate; the existing full_adder cell MAY serve as its bit slice.

Verification (WIDTH=32, STAGES=4, flags enabled unless noted)
REQ-033 a=0xFFFFFFFF, b=1, cin=0, sub=0, out_ready=1 -> 4 cycles later sum=0, cout=1, flags=0b0110.
REQ-034 a=0x7FFFFFFF, b=1, cin=0, sub=0 -> sum=0x80000000, cout=0, flags=0b1001.
REQ-035 a=5, b=7, cin=1, sub=1 -> sum=0xFFFFFFFE, cout=0, flags=0b1000; a=7, b=5 same mode -> sum=2, cout=1, flags=0b0010.
REQ-036 8 back-to-back random operations, out_ready low for 3 cycles mid-stream -> in_ready low while stalled and full, outputs held, all 8 results correct and in order vs. reference model.
REQ-037 rst_n low for 1 cycle with 3 transactions in flight -> out_valid=0, sum=0 next cycle, no stale result ever emerges afterwards.
REQ-038 Rebuild with STAGES=1 and with macro undefined -> latency 1, results match model; flags port absent.
